// File: rtl/pipe_dmem_ctrl.sv
// rtl/pipe_dmem_ctrl.sv - MEM-stage data memory controller: sub-word loads/stores over a word RAM
// Sub-word stores are read-modify-write; loads are extended in the DONE state.
module pipe_dmem_ctrl #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misalign,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic [31:0] a_addr;
    logic        a_wr;
    logic [1:0]  a_size;
    logic        a_sext;
    logic [31:0] a_wdata;
    logic [31:0] dreg;

    logic        aligned;
    logic        accept;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] merged;
    logic [31:0] load_val;

    always_comb begin
        case (size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            default: aligned = (addr[1:0] == 2'b00);
        endcase
    end

    assign accept = (state == S_IDLE) && req && aligned;

    // Lane selection always uses the latched address, never the live pipeline inputs.
    always_comb begin
        byte_v = dreg[{a_addr[1:0], 3'b000} +: 8];
        half_v = dreg[{a_addr[1], 4'b0000} +: 16];
        merged = dreg;
        case (a_size)
            2'b00:   merged[{a_addr[1:0], 3'b000} +: 8] = a_wdata[7:0];
            2'b01:   merged[{a_addr[1], 4'b0000} +: 16] = a_wdata[15:0];
            default: merged = a_wdata;
        endcase
        case (a_size)
            2'b00:   load_val = {{24{a_sext & byte_v[7]}}, byte_v};
            2'b01:   load_val = {{16{a_sext & half_v[15]}}, half_v};
            default: load_val = dreg;
        endcase
    end

    assign stall    = ~rst && ((state == S_RD) || (state == S_WR) || accept);
    assign misalign = ~rst && (state == S_IDLE) && req && ~aligned;
    assign done     = ~rst && ((state == S_DONE) || misalign);
    assign mem_we   = ~rst && (state == S_WR);
    assign mem_addr = (rst || state == S_IDLE) ? 32'h0 : {a_addr[31:2], 2'b00};
    assign mem_din  = mem_we ? merged : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            a_addr  <= 32'h0;
            a_wr    <= 1'b0;
            a_size  <= 2'b00;
            a_sext  <= 1'b0;
            a_wdata <= 32'h0;
            dreg    <= 32'h0;
            rdata   <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_addr  <= addr;
                        a_wr    <= wr;
                        a_size  <= size;
                        a_sext  <= sext;
                        a_wdata <= wdata;
                        cnt     <= 3'(RD_LAT - 1);
                        state   <= (wr && size[1]) ? S_WR : S_RD;
                    end
                end
                S_RD: begin
                    if (cnt == 3'd0) begin
                        dreg  <= mem_dout;
                        state <= a_wr ? S_WR : S_DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_WR: state <= S_DONE;
                default: begin
                    if (!a_wr) rdata <= load_val;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_dmem_ctrl.sv
// tb/tb_pipe_dmem_ctrl.sv - scoreboard bench for pipe_dmem_ctrl with a registered word-RAM model
module tb_pipe_dmem_ctrl;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        misalign;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    pipe_dmem_ctrl #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done),
        .misalign(misalign), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        logic        mis;
        logic [31:0] din;
        bit          is_store;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ram[0:63];
    logic [31:0] seed_mem[0:63];
    logic [31:0] exp_mem[0:63];
    logic [31:0] last_rdata;
    logic [31:0] last_din;
    int          we_count;
    bit          preload;
    int          checks;
    int          failures;

    // One register stage between address and data matches RD_LAT=2.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram[i] <= seed_mem[i];
        end else if (mem_we) begin
            ram[mem_addr[7:2]] <= mem_din;
            we_count <= we_count + 1;
            last_din <= mem_din;
        end
        mem_dout <= ram[mem_addr[7:2]];
    end

    function automatic bit model_aligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b00) return 1'b1;
        if (sz == 2'b01) return a[0] == 1'b0;
        return a[1:0] == 2'b00;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
        logic [31:0] sh;
        sh = exp_mem[a[7:2]] >> (8 * a[1:0]);
        if (sz == 2'b00) return sx ? 32'(signed'(sh[7:0])) : (sh & 32'hFF);
        if (sz == 2'b01) return sx ? 32'(signed'(sh[15:0])) : (sh & 32'hFFFF);
        return exp_mem[a[7:2]];
    endfunction

    function automatic logic [31:0] model_merge(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] m;
        if (sz[1]) return wd;
        m = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << (8 * a[1:0]);
        return (exp_mem[a[7:2]] & ~m) | ((wd << (8 * a[1:0])) & m);
    endfunction

    task automatic run_access(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd,
                              input bit drop_req, input string name);
        exp_t e;
        exp_t g;
        int   cyc;
        int   we_cyc;
        int   we0;
        bit   got;
        bit   stall_bad;
        bit   addr_bad;
        logic mis_seen;
        e.mis = !model_aligned(sz, a);
        e.is_store = w && !e.mis;
        e.din = 32'h0;
        e.rdata = last_rdata;
        if (e.mis) e.lat = 0;
        else if (!w) begin
            e.lat = RD_LAT + 1;
            e.rdata = model_load(sz, sx, a);
        end else begin
            e.lat = sz[1] ? 2 : RD_LAT + 2;
            e.din = model_merge(sz, a, wd);
            exp_mem[a[7:2]] = e.din;
        end
        exp_q.push_back(e);

        @(negedge clk);
        req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = wd;
        #1;
        cyc = 0; got = 0; we_cyc = -1; we0 = we_count;
        stall_bad = 0; addr_bad = 0; mis_seen = 1'b0;
        while (cyc < 20) begin
            if (mem_we) we_cyc = cyc;
            if (cyc >= 1 && mem_addr !== {a[31:2], 2'b00}) addr_bad = 1;
            if (cyc == 0 && e.mis && mem_addr !== 32'h0) addr_bad = 1;
            if (done) begin
                got = 1;
                mis_seen = misalign;
                if (stall !== 1'b0) stall_bad = 1;
                break;
            end
            if (stall !== 1'b1) stall_bad = 1;
            cyc++;
            @(negedge clk);
            if (drop_req && cyc == 1) begin
                req = 1'b0; wr = ~w; addr = $urandom; wdata = $urandom; size = ~sz; sext = ~sx;
            end
            #1;
        end
        g = exp_q.pop_front();

        checks++;
        if (!got || cyc !== g.lat) begin
            failures++;
            $display("FAIL %s latency: got %0d (done seen=%0d), expected %0d", name, cyc, got, g.lat);
        end
        checks++;
        if (stall_bad) begin
            failures++;
            $display("FAIL %s stall: stall profile wrong, expected 1 until done then 0", name);
        end
        checks++;
        if (mis_seen !== g.mis) begin
            failures++;
            $display("FAIL %s misalign: got %b, expected %b", name, mis_seen, g.mis);
        end
        checks++;
        if (addr_bad) begin
            failures++;
            $display("FAIL %s mem_addr: wrong word address during access, expected %h", name, {a[31:2], 2'b00});
        end
        checks++;
        if ((we_count - we0) !== (g.is_store ? 1 : 0) || (g.is_store && we_cyc !== g.lat - 1)) begin
            failures++;
            $display("FAIL %s mem_we: pulses=%0d at cycle %0d, expected %0d at cycle %0d",
                     name, we_count - we0, we_cyc, g.is_store ? 1 : 0, g.lat - 1);
        end
        if (g.is_store) begin
            checks++;
            if (last_din !== g.din) begin
                failures++;
                $display("FAIL %s mem_din: got %h, expected %h", name, last_din, g.din);
            end
        end

        @(negedge clk);
        req = 1'b0;
        #1;
        checks++;
        if (rdata !== g.rdata) begin
            failures++;
            $display("FAIL %s rdata: got %h, expected %h", name, rdata, g.rdata);
        end
        last_rdata = g.rdata;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h10; sext = 1'b0; wdata = 32'h0;
        #1;
        checks++;
        if ({stall, done, misalign, mem_we} !== 4'b0 || mem_addr !== 32'h0 || mem_din !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: stall=%b done=%b mis=%b we=%b addr=%h din=%h, expected all 0",
                     stall, done, misalign, mem_we, mem_addr, mem_din);
        end
        @(negedge clk);
        preload = 1'b0;
        rst = 1'b0; req = 1'b0;
        #1;
        checks++;
        if (rdata !== 32'h0 || stall !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: rdata=%h stall=%b done=%b, expected 0 0 0", rdata, stall, done);
        end
        last_rdata = 32'h0;
    endtask

    task automatic test_loads();
        run_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, "load_byte_sext");
        checks++;
        if (rdata !== 32'hFFFFFF88) begin
            failures++;
            $display("FAIL load_byte_const: got %h, expected ffffff88", rdata);
        end
        run_access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0, "load_half_zext");
        checks++;
        if (rdata !== 32'h0000AABB) begin
            failures++;
            $display("FAIL load_half_zext_const: got %h, expected 0000aabb", rdata);
        end
        run_access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0, "load_half_sext");
        checks++;
        if (rdata !== 32'hFFFFAABB) begin
            failures++;
            $display("FAIL load_half_sext_const: got %h, expected ffffaabb", rdata);
        end
    endtask

    task automatic test_stores();
        run_access(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000CC, 0, "store_byte");
        run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, "load_word_after_store");
        checks++;
        if (rdata !== 32'h8899CCBB) begin
            failures++;
            $display("FAIL store_byte_readback: got %h, expected 8899ccbb", rdata);
        end
        run_access(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 0, "store_word");
        run_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 1, "store_half_req_drop");
        run_access(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1, "load_size3_req_drop");
        checks++;
        if (rdata !== 32'hBEEF5678) begin
            failures++;
            $display("FAIL half_store_readback: got %h, expected beef5678", rdata);
        end
    endtask

    task automatic test_misalign();
        run_access(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 0, "misalign_word_load");
        run_access(1'b1, 2'b01, 1'b0, 32'h11, 32'h1234, 0, "misalign_half_store");
        run_access(1'b1, 2'b11, 1'b0, 32'h13, 32'h1234, 0, "misalign_size3_store");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = {24'h0, 8'($urandom_range(0, 255))};
            run_access(1'($urandom), sz, 1'($urandom), a, $urandom, bit'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_reset_in_wr();
        int cyc;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h11; wdata = 32'h55;
        #1;
        cyc = 0;
        while (cyc < 20 && !mem_we) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc !== RD_LAT + 1) begin
            failures++;
            $display("FAIL rst_wr_reach: WR reached at cycle %0d, expected %0d", cyc, RD_LAT + 1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_wr_gate: we=%b done=%b stall=%b, expected 0 0 0", mem_we, done, stall);
        end
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'h0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_wr_idle: done=%b stall=%b mem_addr=%h rdata=%h, expected 0 0 0 0",
                     done, stall, mem_addr, rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ram[4] !== exp_mem[4] || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_wr_ram: ram=%h done=%b, expected %h 0", ram[4], done, exp_mem[4]);
        end
        last_rdata = 32'h0;
    endtask

    task automatic test_ram_contents();
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) if (ram[i] !== exp_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ram_contents: %0d words differ, expected 0", bad);
        end
    endtask

    initial begin
        checks = 0; failures = 0; we_count = 0; last_din = 32'h0; preload = 1'b1;
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0; addr = 32'h0; wdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            seed_mem[i] = $urandom;
            exp_mem[i]  = seed_mem[i];
        end
        seed_mem[4] = 32'h8899AABB;
        exp_mem[4]  = 32'h8899AABB;
        test_reset();
        test_loads();
        test_stores();
        test_misalign();
        test_back_to_back();
        test_reset_in_wr();
        test_ram_contents();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_dmem_ctrl.md
PIPE_DMEM_CTRL -- requirements
Module: pipe_dmem_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning cycles from mem_addr stable to mem_dout valid (legal 1..4).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port req  in  1  MEM-stage access valid, held by the pipeline while stall=1.
REQ-005 SHALL have port wr  in  1  1=store, 0=load.
REQ-006 SHALL have port size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-007 SHALL have port sext  in  1  loads only: 1 sign-extend, 0 zero-extend.
REQ-008 SHALL have port addr  in  32  byte address.
REQ-009 SHALL have port wdata  in  32  store data, right-justified for byte/half.
REQ-010 SHALL have port rdata  out  32  load result, extended.
REQ-011 SHALL have port stall  out  1  pipeline hold request.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port misalign  out  1  misaligned-access flag.
REQ-014 SHALL have port mem_we  out  1  word-RAM write enable.
REQ-015 SHALL have port mem_addr  out  32  word-RAM address, bits [1:0] always 00.
REQ-016 SHALL have port mem_din  out  32  word-RAM write data.
REQ-017 SHALL have port mem_dout  in  32  word-RAM read data.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, DONE.
REQ-019 IDLE with req=1 and aligned access SHALL latch addr, wr, size, sext, wdata, assert stall combinationally, and go to RD (load or byte/half store) or WR (word store).
REQ-020 Alignment: half SHALL need addr[0]=0; word/size 11 SHALL need addr[1:0]=00; byte is always aligned.
REQ-021 Misaligned req in IDLE SHALL assert misalign=1 and done=1 in that cycle, with stall=0, no memory access, no state change, and rdata unchanged.
REQ-022 mem_addr SHALL equal {latched addr[31:2],2'b00} in RD, WR, and DONE, and 0 in IDLE.
REQ-023 RD SHALL last exactly RD_LAT cycles via a down-counter, capturing mem_dout into a data register on the last RD cycle.
REQ-024 From RD, loads SHALL go to DONE and sub-word stores SHALL go to WR.
REQ-025 WR SHALL last one cycle with mem_we=1 and then go to DONE; mem_we SHALL be 0 in all other states.
REQ-026 mem_din in WR SHALL be: word store = wdata; sub-word store = captured word with the addressed lane replaced, all other bytes preserved.
REQ-027 Lanes SHALL be little-endian: byte k = bits [8k+7:8k] with k=addr[1:0]; half lane = bits [16*addr[1]+15:16*addr[1]].
REQ-028 For a load, DONE SHALL update rdata from the captured word: byte/half lane extended per sext, word passed unchanged; stores SHALL leave rdata unchanged.
REQ-029 DONE SHALL assert done=1 with stall=0 for one cycle and return to IDLE; a req seen in the following IDLE cycle SHALL be a new access.
REQ-030 stall SHALL be 1 in RD and WR, 1 in IDLE when an aligned req is present, and 0 otherwise.
REQ-031 Latency from acceptance cycle to done: load RD_LAT+1, word store 2, sub-word store RD_LAT+2.
REQ-032 req deasserting mid-operation SHALL be ignored; the latched access completes.

Reset
REQ-033 On a clock edge with rst=1, state SHALL become IDLE and the counter, latched fields, data register, and rdata SHALL become 0.
REQ-034 stall, done, misalign, mem_we, mem_addr, and mem_din SHALL be 0 while rst=1.
REQ-035 mem_we SHALL be gated by ~rst so that reset during WR commits no write; reset in any state SHALL abort the access without done.

Verification
REQ-036 RD_LAT=2, RAM[0x10]=0x8899AABB, load size=00 addr=0x13 sext=1 -> rdata=0xFFFFFF88, done 3 cycles after acceptance, stall high for the preceding 3 cycles.
REQ-037 Same word, load size=01 addr=0x10 sext=0 -> rdata=0x0000AABB; with sext=1 -> 0xFFFFAABB.
REQ-038 Store size=00 addr=0x11 wdata=0x000000CC -> a single mem_we pulse with mem_din=0x8899CCBB; a later word load from 0x10 returns 0x8899CCBB.
REQ-039 Word store addr=0x20 wdata=0x12345678 -> no RD cycles, mem_we in the cycle after acceptance, done the cycle after that.
REQ-040 Load size=10 addr=0x22 -> misalign=1 and done=1 in the same cycle, stall=0, mem_we=0, rdata unchanged.
REQ-041 rst asserted during WR of a sub-word store -> mem_we=0 in that cycle, RAM unchanged, FSM in IDLE next cycle, no done pulse.
